// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold handling.
// Optional perf counters are built when PERF_CNT_EN is defined.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             HoldE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic             ALUSrcD,
  input  logic             MemWriteD,
  input  logic             MemReadD,
  input  logic             ResultSrcD,
  input  logic             BranchD,
  input  logic [1:0]       ALUOpD,
  input  logic [2:0]       funct3D,
  input  logic             funct7b5D,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic             ALUSrcE,
  output logic             MemWriteE,
  output logic             MemReadE,
  output logic             ResultSrcE,
  output logic             BranchE,
  output logic [1:0]       ALUOpE,
  output logic [2:0]       funct3E,
  output logic             funct7b5E,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             StallD,
  output logic [CNT_W-1:0] BubbleCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // Fields cleared on a bubble; RdE is included so a bubble never matches a forward.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic [4:0] rd;
  } ctrl_t;

  typedef struct packed {
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } data_t;

  ctrl_t ctrl_q, ctrl_d;
  data_t data_q, data_d;
  logic  load_use;
  logic  bubble;

  assign load_use = ctrl_q.valid & ctrl_q.mem_read & (ctrl_q.rd != 5'd0) & ValidD &
                    ((Rs1D == ctrl_q.rd) | (Rs2D == ctrl_q.rd));
  assign bubble   = FlushE | load_use | ~ValidD;
  // Flush wins over the load-use stall so fetch can redirect.
  assign StallD   = HoldE | (load_use & ~FlushE);

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (!HoldE) begin
      data_d = '{funct3: funct3D, funct7b5: funct7b5D, rd1: RD1D, rd2: RD2D, imm: ImmExtD,
                 pc: PCD, pc_plus4: PCPlus4D, rs1: Rs1D, rs2: Rs2D};
      if (bubble) begin
        ctrl_d = '0;
      end else begin
        ctrl_d = '{valid: 1'b1, reg_write: RegWriteD, alu_src: ALUSrcD, mem_write: MemWriteD,
                   mem_read: MemReadD, result_src: ResultSrcD, branch: BranchD,
                   alu_op: ALUOpD, rd: RdD};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ValidE     = ctrl_q.valid;
  assign RegWriteE  = ctrl_q.reg_write;
  assign ALUSrcE    = ctrl_q.alu_src;
  assign MemWriteE  = ctrl_q.mem_write;
  assign MemReadE   = ctrl_q.mem_read;
  assign ResultSrcE = ctrl_q.result_src;
  assign BranchE    = ctrl_q.branch;
  assign ALUOpE     = ctrl_q.alu_op;
  assign RdE        = ctrl_q.rd;
  assign funct3E    = data_q.funct3;
  assign funct7b5E  = data_q.funct7b5;
  assign RD1E       = data_q.rd1;
  assign RD2E       = data_q.rd2;
  assign ImmExtE    = data_q.imm;
  assign PCE        = data_q.pc;
  assign PCPlus4E   = data_q.pc_plus4;
  assign Rs1E       = data_q.rs1;
  assign Rs2E       = data_q.rs2;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!HoldE) begin
      if (load_use && !FlushE && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      if (FlushE && (flush_cnt_q != '1))                flush_cnt_d  = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign BubbleCnt = bubble_cnt_q;
  assign FlushCnt  = flush_cnt_q;
`else
  assign BubbleCnt = '0;
  assign FlushCnt  = '0;
`endif

endmodule
